router_reg: RTL

- Datapath register stage of the 1x3 router, directly downstream of the router control FSM.
- Consumes the FSM state decodes to:
  - latch the header byte;
  - sequence payload bytes onto dout toward the destination FIFOs;
  - hold the byte that arrives while the FIFO is full;
  - compute running XOR parity and compare it with the packet's trailing parity byte.
- Produces parity_done and low_pkt_valid, which the FSM consumes, plus err for the source.

---
 rtl/router_reg.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/router_reg.sv
// ---------------------------------------------------------------------------
// router_reg
// Datapath register stage of the 1x3 router. It sits directly behind the
// router control FSM and uses the FSM's one-hot state decodes to:
//   - latch the header byte (address field in [1:0], length above it);
//   - sequence header and payload bytes onto dout toward the destination FIFOs;
//   - hold a byte that arrives while the selected FIFO is full, and replay it
//     once the FSM reaches load_after_full;
//   - keep a running XOR parity over header and payload and compare it with
//     the trailing parity byte of the packet.
//
// Ports
//   clock         in   system clock, all state updates on the rising edge
//   resetn        in   asynchronous active-low reset
//   pkt_valid     in   source byte valid (low on the trailing parity byte)
//   data_in       in   source byte [DATA_WIDTH-1:0]
//   fifo_full     in   selected destination FIFO is full
//   detect_add    in   FSM in decode_addr
//   lfd_state     in   FSM in load_first_data
//   ld_state      in   FSM in load_data
//   laf_state     in   FSM in load_after_full
//   full_state    in   FSM in fifo_full_state
//   rst_int_reg   in   FSM in check_parity_error
//   parity_done   out  parity byte of the packet captured/forwarded
//   low_pkt_valid out  pkt_valid has fallen within the current packet
//   err           out  parity mismatch of the last completed packet
//   dout          out  byte toward the destination FIFO [DATA_WIDTH-1:0]
//
// All outputs come straight from registers; there is no combinational path
// from data_in to any output.
// ---------------------------------------------------------------------------
module router_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] r_dout;
    logic [DATA_WIDTH-1:0] r_header;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_int_parity;
    logic [DATA_WIDTH-1:0] r_pkt_parity;
    logic                  r_parity_done;
    logic                  r_low_pkt_valid;
    logic                  r_err;

    // Address 3 does not exist on a 1x3 router, so such a header is ignored.
    logic w_hdr_load;
    // Parity byte is the only load_data byte with pkt_valid low.
    logic w_parity_byte;
    // A payload byte that contributes to the running parity. Bytes diverted
    // into r_hold are counted here, not again when replayed from r_hold.
    logic w_payload_xor;
    logic w_pdone_set;

    assign w_hdr_load    = detect_add && pkt_valid && (data_in[1:0] != 2'b11);
    assign w_parity_byte = ld_state && !pkt_valid;
    assign w_payload_xor = ld_state && pkt_valid && !full_state;
    assign w_pdone_set   = (ld_state && !fifo_full && !pkt_valid) ||
                           (laf_state && r_low_pkt_valid && !r_parity_done);

    // Header register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_header <= '0;
        end else if (w_hdr_load) begin
            r_header <= data_in;
        end
    end

    // Output byte and full-FIFO holding register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_dout <= '0;
            r_hold <= '0;
        end else if (lfd_state) begin
            r_dout <= r_header;
        end else if (ld_state && !fifo_full) begin
            r_dout <= data_in;
        end else if (ld_state && fifo_full) begin
            r_hold <= data_in;
        end else if (laf_state) begin
            r_dout <= r_hold;
        end
    end

    // Running parity over header and payload
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_int_parity <= '0;
        end else if (detect_add) begin
            r_int_parity <= '0;
        end else if (lfd_state) begin
            r_int_parity <= r_int_parity ^ r_header;
        end else if (w_payload_xor) begin
            r_int_parity <= r_int_parity ^ data_in;
        end
    end

    // Trailing parity byte of the packet, captured even if the FIFO is full
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pkt_parity <= '0;
        end else if (detect_add) begin
            r_pkt_parity <= '0;
        end else if (w_parity_byte) begin
            r_pkt_parity <= data_in;
        end
    end

    // low_pkt_valid: set wins over clear
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_low_pkt_valid <= 1'b0;
        end else if (w_parity_byte) begin
            r_low_pkt_valid <= 1'b1;
        end else if (rst_int_reg) begin
            r_low_pkt_valid <= 1'b0;
        end
    end

    // parity_done: sticky until the next decode_addr
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_parity_done <= 1'b0;
        end else if (w_pdone_set) begin
            r_parity_done <= 1'b1;
        end else if (detect_add) begin
            r_parity_done <= 1'b0;
        end
    end

    // err: only re-evaluated in check_parity_error, otherwise held
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (rst_int_reg) begin
            r_err <= (r_int_parity != r_pkt_parity);
        end
    end

    assign dout          = r_dout;
    assign parity_done   = r_parity_done;
    assign low_pkt_valid = r_low_pkt_valid;
    assign err           = r_err;

endmodule
